// File: rtl/ctrl_pkg.sv
// Shared definitions for the ALU instruction control sequencer:
// opcodes, ALU one-hot bit positions, state encoding and IR field slices.
package ctrl_pkg;

  localparam int NREG_DEF    = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam int ALU_W       = 13;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd9;
  localparam logic [4:0] OP_DIV  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_NOT  = 5'd12;

  // ADD is the MSB of alu_op, NOT the LSB
  localparam int ALU_ADD  = 12;
  localparam int ALU_SUB  = 11;
  localparam int ALU_AND  = 10;
  localparam int ALU_OR   = 9;
  localparam int ALU_SHR  = 8;
  localparam int ALU_SHRA = 7;
  localparam int ALU_SHL  = 6;
  localparam int ALU_ROR  = 5;
  localparam int ALU_ROL  = 4;
  localparam int ALU_MUL  = 3;
  localparam int ALU_DIV  = 2;
  localparam int ALU_NEG  = 1;
  localparam int ALU_NOT  = 0;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2,
    S_T3, S_T4, S_T5, S_T6,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    C_ALU3, C_MULDIV, C_UNARY, C_ILLEGAL
  } op_class_e;

  function automatic op_class_e op_class(
    input logic [4:0] opc
  );
    if (opc <= OP_ROL)
      return C_ALU3;
    else if (opc == OP_MUL || opc == OP_DIV)
      return C_MULDIV;
    else if (opc == OP_NEG || opc == OP_NOT)
      return C_UNARY;
    else
      return C_ILLEGAL;
  endfunction

  function automatic logic [ALU_W-1:0] alu_onehot(
    input logic [4:0] opc
  );
    logic [ALU_W-1:0] v;
    v = '0;
    case (opc)
      OP_ADD:  v[ALU_ADD]  = 1'b1;
      OP_SUB:  v[ALU_SUB]  = 1'b1;
      OP_AND:  v[ALU_AND]  = 1'b1;
      OP_OR:   v[ALU_OR]   = 1'b1;
      OP_SHR:  v[ALU_SHR]  = 1'b1;
      OP_SHRA: v[ALU_SHRA] = 1'b1;
      OP_SHL:  v[ALU_SHL]  = 1'b1;
      OP_ROR:  v[ALU_ROR]  = 1'b1;
      OP_ROL:  v[ALU_ROL]  = 1'b1;
      OP_MUL:  v[ALU_MUL]  = 1'b1;
      OP_DIV:  v[ALU_DIV]  = 1'b1;
      OP_NEG:  v[ALU_NEG]  = 1'b1;
      OP_NOT:  v[ALU_NOT]  = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register index plus enable to one-hot select vector.
module reg_select_decoder #(
  parameter int N = 16
) (
  input  logic [3:0]   idx_i,
  input  logic         en_i,
  output logic [N-1:0] sel_o
);

  always_comb begin
    sel_o = '0;
    if (en_i)
      sel_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Moore control unit: fetch (T0-T2) then execute (T3-T6) of one
// register-register ALU instruction, driving every datapath strobe.
module alu_control_sequencer
  import ctrl_pkg::*;
#(
  parameter int NREG    = NREG_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_rdy,
  input  logic [31:0]      ir,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [NREG-1:0]  Rin_sel,
  output logic [NREG-1:0]  Rout_sel,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [ALU_W-1:0] alu_op
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e      state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [4:0]  op_q;
  logic [3:0]  ra_q, rb_q, rc_q;
  logic [3:0]  rout_idx;
  logic        rin_en, rout_en;
  op_class_e   cls;
  logic        unused_ir;

  assign unused_ir = ^ir[RC_LO-1:0];
  assign cls  = op_class(op_q);
  assign busy = (state_q != S_IDLE) &&
                (state_q != S_FAULT);

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      // fields frozen on the T2->T3 edge for the whole execute phase
      if (state_q == S_T2) begin
        op_q <= ir[OPC_HI:OPC_LO];
        ra_q <= ir[RA_HI:RA_LO];
        rb_q <= ir[RB_HI:RB_LO];
        rc_q <= ir[RC_HI:RC_LO];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    done     = 1'b0;
    fault    = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = '0;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_idx = rb_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d = '0;
        if (start)
          state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // PC is loaded only in the first T1 cycle
        PCin    = (wait_q == '0);
        if (mem_rdy) begin
          state_d = S_T2;
          wait_d  = '0;
        end else if (wait_q + CW'(1) == CW'(TIMEOUT)) begin
          state_d = S_FAULT;
          wait_d  = '0;
        end else begin
          wait_d  = wait_q + CW'(1);
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        unique case (cls)
          C_ALU3, C_MULDIV: begin
            rout_en = 1'b1;
            Yin     = 1'b1;
            state_d = S_T4;
          end
          C_UNARY: begin
            rout_en = 1'b1;
            alu_op  = alu_onehot(op_q);
            Zin     = 1'b1;
            state_d = S_T4;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_T4: begin
        if (cls == C_UNARY) begin
          Zlowout = 1'b1;
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          rout_en  = 1'b1;
          rout_idx = rc_q;
          alu_op   = alu_onehot(op_q);
          Zin      = 1'b1;
          state_d  = S_T5;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (cls == C_ALU3) begin
          rin_en  = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          LOin    = 1'b1;
          state_d = S_T6;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
        state_d  = S_IDLE;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  reg_select_decoder #(.N(NREG)) u_rin (
    .idx_i (ra_q),
    .en_i  (rin_en),
    .sel_o (Rin_sel)
  );

  reg_select_decoder #(.N(NREG)) u_rout (
    .idx_i (rout_idx),
    .en_i  (rout_en),
    .sel_o (Rout_sel)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Directed bench for alu_control_sequencer: fetch/execute strobes,
// T1 wait states, timeout and illegal-opcode faults, clear mid-instruction.
module tb_alu_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        mem_rdy = 1'b1;
  logic [31:0] ir = '0;
  logic        busy, done, fault;
  logic [15:0] Rin_sel, Rout_sel;
  logic        PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin;
  logic        Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [12:0] alu_op;
  logic [13:0] strb;

  int checks = 0;
  int errors = 0;

  localparam logic [13:0] M_PCOUT  = 14'h2000;
  localparam logic [13:0] M_MARIN  = 14'h1000;
  localparam logic [13:0] M_INCPC  = 14'h0800;
  localparam logic [13:0] M_ZIN    = 14'h0400;
  localparam logic [13:0] M_ZLO    = 14'h0200;
  localparam logic [13:0] M_ZHI    = 14'h0100;
  localparam logic [13:0] M_PCIN   = 14'h0080;
  localparam logic [13:0] M_READ   = 14'h0040;
  localparam logic [13:0] M_MDRIN  = 14'h0020;
  localparam logic [13:0] M_MDROUT = 14'h0010;
  localparam logic [13:0] M_IRIN   = 14'h0008;
  localparam logic [13:0] M_YIN    = 14'h0004;
  localparam logic [13:0] M_HIIN   = 14'h0002;
  localparam logic [13:0] M_LOIN   = 14'h0001;

  localparam logic [13:0] F0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [13:0] F1  = M_ZLO | M_PCIN | M_READ | M_MDRIN;
  localparam logic [13:0] F1W = M_ZLO | M_READ | M_MDRIN;
  localparam logic [13:0] F2  = M_MDROUT | M_IRIN;

  localparam logic [2:0] B = 3'b100;
  localparam logic [2:0] D = 3'b010;
  localparam logic [2:0] F = 3'b001;

  assign strb = {PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin,
                 Read, MDRin, MDRout, IRin, Yin, HIin, LOin};

  always #5 clock = ~clock;

  alu_control_sequencer dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .mem_rdy  (mem_rdy),
    .ir       (ir),
    .busy     (busy),
    .done     (done),
    .fault    (fault),
    .Rin_sel  (Rin_sel),
    .Rout_sel (Rout_sel),
    .PCout    (PCout),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .Zin      (Zin),
    .Zlowout  (Zlowout),
    .Zhighout (Zhighout),
    .PCin     (PCin),
    .Read     (Read),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .HIin     (HIin),
    .LOin     (LOin),
    .alu_op   (alu_op)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [13:0] s,
                            input logic [15:0] rin, input logic [15:0] rout,
                            input logic [12:0] alu, input logic [2:0] bdf);
    chk({tag, ".strb"}, 32'(strb), 32'(s));
    chk({tag, ".rin"}, 32'(Rin_sel), 32'(rin));
    chk({tag, ".rout"}, 32'(Rout_sel), 32'(rout));
    chk({tag, ".alu"}, 32'(alu_op), 32'(alu));
    chk({tag, ".bdf"}, 32'({busy, done, fault}), 32'(bdf));
  endtask

  // expects start=1 and mem_rdy=1 on entry; leaves DUT in T2
  task automatic fetch(input string tag);
    tick;
    start = 1'b0;
    expect_out({tag, ".T0"}, F0, '0, '0, '0, B);
    tick;
    expect_out({tag, ".T1"}, F1, '0, '0, '0, B);
    tick;
    expect_out({tag, ".T2"}, F2, '0, '0, '0, B);
  endtask

  initial begin
    tick;
    tick;
    clear = 1'b0;
    expect_out("reset", '0, '0, '0, '0, '0);

    // SHRA R7 <- R0 >>> R4
    ir = 32'h2B820000;
    start = 1'b1;
    fetch("shra");
    tick;
    ir = 32'hFFFFFFFF;
    expect_out("shra.T3", M_YIN, '0, 16'h0001, '0, B);
    tick;
    expect_out("shra.T4", M_ZIN, '0, 16'h0010, 13'h0080, B);
    tick;
    expect_out("shra.T5", M_ZLO, 16'h0080, '0, '0, B | D);
    tick;
    expect_out("shra.idle", '0, '0, '0, '0, '0);

    // ADD R2 <- R5 + R6 with three T1 wait cycles
    ir = 32'h012B0000;
    mem_rdy = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    expect_out("add.T0", F0, '0, '0, '0, B);
    tick;
    expect_out("add.T1", F1, '0, '0, '0, B);
    for (int i = 1; i <= 3; i++) begin
      tick;
      expect_out($sformatf("add.T1w%0d", i), F1W, '0, '0, '0, B);
    end
    mem_rdy = 1'b1;
    tick;
    expect_out("add.T2", F2, '0, '0, '0, B);
    tick;
    expect_out("add.T3", M_YIN, '0, 16'h0020, '0, B);
    tick;
    start = 1'b1;
    expect_out("add.T4", M_ZIN, '0, 16'h0040, 13'h1000, B);
    tick;
    expect_out("add.T5", M_ZLO, 16'h0004, '0, '0, B | D);
    ir = 32'h48188000;
    tick;
    expect_out("add.idle", '0, '0, '0, '0, '0);

    // MUL R3 * R1, restarted by start held through done
    fetch("mul");
    tick;
    expect_out("mul.T3", M_YIN, '0, 16'h0008, '0, B);
    tick;
    expect_out("mul.T4", M_ZIN, '0, 16'h0002, 13'h0008, B);
    tick;
    expect_out("mul.T5", M_ZLO | M_LOIN, '0, '0, '0, B);
    tick;
    expect_out("mul.T6", M_ZHI | M_HIIN, '0, '0, '0, B | D);
    tick;
    expect_out("mul.idle", '0, '0, '0, '0, '0);

    // NEG R4 <- -R9
    ir = 32'h5A480000;
    start = 1'b1;
    fetch("neg");
    tick;
    expect_out("neg.T3", M_ZIN, '0, 16'h0200, 13'h0002, B);
    tick;
    expect_out("neg.T4", M_ZLO, 16'h0010, '0, '0, B | D);
    tick;
    expect_out("neg.idle", '0, '0, '0, '0, '0);

    // illegal opcode
    ir = 32'hF8000000;
    start = 1'b1;
    fetch("ill");
    tick;
    expect_out("ill.T3", '0, '0, '0, '0, B);
    tick;
    expect_out("ill.fault", '0, '0, '0, '0, F);
    start = 1'b1;
    tick;
    start = 1'b0;
    expect_out("ill.stay", '0, '0, '0, '0, F);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    expect_out("ill.clear", '0, '0, '0, '0, '0);

    // memory timeout
    ir = 32'h012B0000;
    mem_rdy = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    repeat (14) tick;
    expect_out("tmo.T1last", F1W, '0, '0, '0, B);
    tick;
    expect_out("tmo.fault", '0, '0, '0, '0, F);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    mem_rdy = 1'b1;
    expect_out("tmo.clear", '0, '0, '0, '0, '0);

    // clear during T4, then a full restart
    ir = 32'h2B820000;
    start = 1'b1;
    fetch("clr");
    tick;
    tick;
    expect_out("clr.T4", M_ZIN, '0, 16'h0010, 13'h0080, B);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    expect_out("clr.idle", '0, '0, '0, '0, '0);
    start = 1'b1;
    fetch("rst");
    tick;
    tick;
    tick;
    expect_out("rst.T5", M_ZLO, 16'h0080, '0, '0, B | D);
    tick;
    expect_out("rst.idle", '0, '0, '0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
